// File: rtl/sram_responder.sv
// Bridges the 32-bit MEM-stage load/store port to a 16-bit asynchronous SRAM.
// Each access runs as two half-word phases (low then high) of SRAM_WAIT cycles each.
module sram_responder #(
    parameter int unsigned SRAM_WAIT = 3,
    parameter logic [31:0] BASE_ADDR = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_w_en,
    input  logic        MEM_r_en,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ready,
    output logic [17:0] SRAM_ADDR,
    inout  wire  [15:0] SRAM_DQ,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    localparam logic [3:0] LAST = 4'(SRAM_WAIT - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic        op_write;
    logic [16:0] word;
    logic [31:0] wdata;
    logic        dq_oe;
    logic [15:0] dq_out;
    logic [16:0] word_next;

    // Negative offsets wrap modulo 2^17 words; byte-lane bits are dropped.
    assign word_next = 17'((address - BASE_ADDR) >> 2);

    assign SRAM_DQ   = dq_oe ? dq_out : 16'bz;
    assign SRAM_OE_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

    always_comb begin
        ready = 1'b0;
        if (state == DONE)
            ready = 1'b1;
        else if (state == IDLE && !MEM_w_en && !MEM_r_en)
            ready = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            op_write  <= 1'b0;
            word      <= '0;
            wdata     <= '0;
            data_out  <= '0;
            SRAM_ADDR <= '0;
            SRAM_WE_N <= 1'b1;
            dq_oe     <= 1'b0;
            dq_out    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (MEM_w_en || MEM_r_en) begin
                        op_write  <= MEM_w_en;
                        word      <= word_next;
                        wdata     <= data_in;
                        cnt       <= '0;
                        SRAM_ADDR <= {word_next, 1'b0};
                        SRAM_WE_N <= ~MEM_w_en;
                        dq_oe     <= MEM_w_en;
                        dq_out    <= data_in[15:0];
                        state     <= LOW;
                    end
                end
                LOW: begin
                    if (cnt == LAST) begin
                        cnt       <= '0;
                        if (!op_write)
                            data_out[15:0] <= SRAM_DQ;
                        SRAM_ADDR <= {word, 1'b1};
                        dq_out    <= wdata[31:16];
                        state     <= HIGH;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                HIGH: begin
                    if (cnt == LAST) begin
                        cnt       <= '0;
                        if (!op_write)
                            data_out[31:16] <= SRAM_DQ;
                        SRAM_WE_N <= 1'b1;
                        dq_oe     <= 1'b0;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_responder.sv
// Scoreboard bench for sram_responder: behavioural SRAM plus a word-level shadow of expected contents.
module tb_sram_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        MEM_w_en, MEM_r_en;
    logic [31:0] address, data_in;
    logic [31:0] data_out;
    logic        ready;
    logic [17:0] SRAM_ADDR;
    wire  [15:0] SRAM_DQ;
    logic        SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] mem [0:262143];
    int          we_even = 0;
    int          we_odd  = 0;
    logic [31:0] shadow [logic [16:0]];
    logic [31:0] exp_q [$];
    logic [31:0] last_read = '0;

    sram_responder #(.SRAM_WAIT(3), .BASE_ADDR(32'd1024)) dut (
        .clk(clk), .rst(rst), .MEM_w_en(MEM_w_en), .MEM_r_en(MEM_r_en),
        .address(address), .data_in(data_in), .data_out(data_out), .ready(ready),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ(SRAM_DQ), .SRAM_WE_N(SRAM_WE_N),
        .SRAM_OE_N(SRAM_OE_N), .SRAM_CE_N(SRAM_CE_N), .SRAM_UB_N(SRAM_UB_N),
        .SRAM_LB_N(SRAM_LB_N)
    );

    always #5 clk = ~clk;

    // Asynchronous SRAM: drives the bus whenever not being written.
    assign SRAM_DQ = SRAM_WE_N ? mem[SRAM_ADDR] : 16'bz;

    always @(posedge clk) begin
        if (!SRAM_WE_N) begin
            mem[SRAM_ADDR] <= SRAM_DQ;
            if (SRAM_ADDR[0]) we_odd  <= we_odd + 1;
            else              we_even <= we_even + 1;
        end
    end

    task automatic run_access(input logic w, input logic r, input logic [31:0] addr,
                              input logic [31:0] wd, input bit hold, input string name);
        logic [16:0] wrd;
        logic [17:0] lo_a;
        logic [31:0] exp;
        int          low, e0, o0;
        bit          done;
        wrd  = 17'((addr - 32'd1024) >> 2);
        lo_a = {wrd, 1'b0};
        e0 = we_even;
        o0 = we_odd;
        if (w) shadow[wrd] = wd;
        else   exp_q.push_back(shadow.exists(wrd) ? shadow[wrd] : 32'h0);
        @(negedge clk);
        MEM_w_en = w; MEM_r_en = r; address = addr; data_in = wd;
        #1;
        low = 0; done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (ready) done = 1;
            else begin low++; @(posedge clk); #1; end
        end
        n_tests++;
        if (!done || low != 7) begin
            n_fail++;
            $display("FAIL %s_latency: ready-low cycles=%0d done=%0d, required 7", name, low, done);
        end
        if (!w) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL %s_scoreboard: queue empty, data_out=%h", name, data_out);
            end else begin
                exp = exp_q.pop_front();
                if (data_out !== exp) begin
                    n_fail++;
                    $display("FAIL %s_rdata: data_out=%h required %h", name, data_out, exp);
                end
                last_read = exp;
            end
        end else begin
            n_tests++;
            if (mem[lo_a] !== wd[15:0] || mem[lo_a | 18'd1] !== wd[31:16]) begin
                n_fail++;
                $display("FAIL %s_sram: mem[%h]=%h mem[%h]=%h required %h/%h", name, lo_a,
                         mem[lo_a], lo_a | 18'd1, mem[lo_a | 18'd1], wd[15:0], wd[31:16]);
            end
            n_tests++;
            if (we_even - e0 != 3 || we_odd - o0 != 3) begin
                n_fail++;
                $display("FAIL %s_we_cycles: low=%0d high=%0d required 3/3", name, we_even - e0, we_odd - o0);
            end
            n_tests++;
            if (data_out !== last_read) begin
                n_fail++;
                $display("FAIL %s_dout_kept: data_out=%h required %h", name, data_out, last_read);
            end
        end
        if (!hold) begin
            MEM_w_en = 0; MEM_r_en = 0;
            @(posedge clk); #1;
            n_tests++;
            if (ready !== 1'b1 || SRAM_WE_N !== 1'b1) begin
                n_fail++;
                $display("FAIL %s_idle: ready=%b we_n=%b required 1/1", name, ready, SRAM_WE_N);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1; MEM_w_en = 0; MEM_r_en = 0; address = '0; data_in = '0;
        #1;
        n_tests++;
        if (data_out !== 32'h0 || SRAM_ADDR !== 18'h0 || SRAM_WE_N !== 1'b1 || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: dout=%h addr=%h we_n=%b ready=%b required 0/0/1/1",
                     data_out, SRAM_ADDR, SRAM_WE_N, ready);
        end
        n_tests++;
        if ({SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ties: oe/ce/ub/lb=%b required 0000",
                     {SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N});
        end
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 0;
    endtask

    task automatic test_basic;
        run_access(1, 0, 32'd1024, 32'hDEADBEEF, 0, "wr1024");
        run_access(0, 1, 32'd1024, 32'h0, 0, "rd1024");
    endtask

    task automatic test_multi;
        run_access(1, 0, 32'd1032, 32'h12345678, 0, "wr1032");
        run_access(1, 0, 32'd1036, 32'hCAFEF00D, 0, "wr1036");
        run_access(0, 1, 32'd1032, 32'h0, 0, "rd1032");
        run_access(0, 1, 32'd1035, 32'h0, 0, "rd1035_unaligned");
        run_access(0, 1, 32'd1036, 32'h0, 0, "rd1036");
    endtask

    task automatic test_both_high;
        run_access(1, 1, 32'd1040, 32'h0BADF00D, 0, "both_high");
        run_access(0, 1, 32'd1040, 32'h0, 0, "rd1040");
    endtask

    task automatic test_wrap;
        run_access(1, 0, 32'd1020, 32'hA5A55A5A, 0, "wr_wrap");
        n_tests++;
        if (mem[18'h3FFFE] !== 16'h5A5A || mem[18'h3FFFF] !== 16'hA5A5) begin
            n_fail++;
            $display("FAIL wrap_addr: mem[3fffe]=%h mem[3ffff]=%h required 5a5a/a5a5",
                     mem[18'h3FFFE], mem[18'h3FFFF]);
        end
        run_access(0, 1, 32'd1020, 32'h0, 0, "rd_wrap");
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        MEM_r_en = 1; address = 32'd1036;
        repeat (5) @(posedge clk);
        #1 rst = 1;
        #1;
        MEM_r_en = 0;
        #1;
        n_tests++;
        if (data_out !== 32'h0 || SRAM_WE_N !== 1'b1 || SRAM_ADDR !== 18'h0 || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_state: dout=%h we_n=%b addr=%h ready=%b required 0/1/0/1",
                     data_out, SRAM_WE_N, SRAM_ADDR, ready);
        end
        n_tests++;
        if (SRAM_DQ !== mem[SRAM_ADDR]) begin
            n_fail++;
            $display("FAIL abort_bus: dq=%h required released (sram value %h)", SRAM_DQ, mem[SRAM_ADDR]);
        end
        @(posedge clk);
        @(negedge clk); rst = 0;
        last_read = '0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_tests++;
            if (ready !== 1'b1 || SRAM_WE_N !== 1'b1 || data_out !== 32'h0) begin
                n_fail++;
                $display("FAIL abort_no_resume: ready=%b we_n=%b dout=%h required 1/1/0",
                         ready, SRAM_WE_N, data_out);
            end
        end
        run_access(0, 1, 32'd1024, 32'h0, 0, "rd_after_abort");
    endtask

    task automatic test_back_to_back;
        int e0, o0;
        e0 = we_even; o0 = we_odd;
        run_access(1, 0, 32'd1048, 32'h11112222, 1, "b2b_wr0");
        @(posedge clk);
        run_access(1, 0, 32'd1052, 32'h33334444, 1, "b2b_wr1");
        @(posedge clk);
        run_access(0, 1, 32'd1048, 32'h0, 1, "b2b_rd0");
        @(posedge clk);
        run_access(0, 1, 32'd1052, 32'h0, 0, "b2b_rd1");
        n_tests++;
        if (we_even - e0 != 6 || we_odd - o0 != 6) begin
            n_fail++;
            $display("FAIL b2b_we_total: low=%0d high=%0d required 6/6", we_even - e0, we_odd - o0);
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_queue: %0d leftover entries, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_multi;
        test_both_high;
        test_wrap;
        test_reset_mid;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
